key_onehot_scanner: RTL and testbench

Upstream stage for the 8-to-3 non-priority encoder. It synchronises and debounces eight raw key/switch lines and rejects simultaneous presses. For each clean single-key press it presents a stable one-hot `Din` vector with an active-low `en`, so the encoder never sees a bounce, glitch or multi-hot code. It also raises a one-cycle `key_valid` strobe per accepted press and a sticky `multi_err` flag while an illegal multi-key press is held.

---
 rtl/key_scan_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/key_onehot_scanner.sv | 137 +++++++++++++
 tb/tb_key_onehot_scanner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the key scanner that feeds the 8-to-3 encoder.
package key_scan_pkg;

    localparam int KEY_WIDTH            = 8;
    localparam int KEY_DEBOUNCE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        MULTI,
        RELEASE
    } key_state_t;

    // True only for a nonzero vector with a single bit set.
    function automatic logic is_onehot(input logic [KEY_WIDTH-1:0] v);
        return (v != '0) && ((v & (v - KEY_WIDTH'(1))) == '0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; clears to zero on reset.
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_onehot_scanner.sv
// Debounces eight key lines and presents a clean one-hot code (active-low en) to the encoder.
module key_onehot_scanner
    import key_scan_pkg::*;
#(
    parameter int WIDTH           = KEY_WIDTH,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] Din,
    output logic             en,
    output logic             key_valid,
    output logic             multi_err
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] ks;

    key_state_t       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [WIDTH-1:0] captured_d, captured_q;
    logic [WIDTH-1:0] din_d, din_q;
    logic             en_d, en_q;
    logic             key_valid_d, key_valid_q;
    logic             multi_err_d, multi_err_q;

    sync_2ff #(
        .WIDTH(WIDTH)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (key_raw),
        .q    (ks)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            captured_q  <= '0;
            din_q       <= '0;
            en_q        <= 1'b1;
            key_valid_q <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            captured_q  <= captured_d;
            din_q       <= din_d;
            en_q        <= en_d;
            key_valid_q <= key_valid_d;
            multi_err_q <= multi_err_d;
        end
    end

    // Any change of the sampled pattern restarts the stability count in DEBOUNCE and RELEASE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        case (state_q)
            IDLE: begin
                if (ks != '0) begin
                    state_d    = DEBOUNCE;
                    captured_d = ks;
                    cnt_d      = '0;
                end
            end
            DEBOUNCE: begin
                if (ks == '0) begin
                    state_d = IDLE;
                end else if (ks != captured_q) begin
                    captured_d = ks;
                    cnt_d      = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (is_onehot(captured_q)) begin
                    state_d = HELD;
                end else begin
                    state_d = MULTI;
                end
            end
            HELD: begin
                if (ks != captured_q) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            MULTI: begin
                if (ks == '0) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (ks != '0) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the upcoming state so they change on the transition edge itself.
    always_comb begin
        din_d       = '0;
        en_d        = 1'b1;
        key_valid_d = 1'b0;
        multi_err_d = 1'b0;
        if (state_d == HELD) begin
            din_d = captured_q;
            en_d  = 1'b0;
        end
        if (state_q == DEBOUNCE && state_d == HELD) begin
            key_valid_d = 1'b1;
        end
        if (state_d == MULTI) begin
            multi_err_d = 1'b1;
        end
    end

    assign Din       = din_q;
    assign en        = en_q;
    assign key_valid = key_valid_q;
    assign multi_err = multi_err_q;

endmodule

// File: tb/tb_key_onehot_scanner.sv
// Scoreboard bench for key_onehot_scanner: expected accepted presses are queued at drive time.
module tb_key_onehot_scanner;
    import key_scan_pkg::*;

    typedef struct {
        logic [7:0] din;
        int         cyc;
        int         idx;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_raw;
    logic [7:0] Din;
    logic       en;
    logic       key_valid;
    logic       multi_err;

    int   checks;
    int   errors;
    int   cycle;
    exp_t sb[$];
    exp_t mon_e;

    key_onehot_scanner #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_raw  (key_raw),
        .Din      (Din),
        .en       (en),
        .key_valid(key_valid),
        .multi_err(multi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", tag, actual, expected, cycle);
        end
    endtask

    function automatic int encode(input logic [7:0] v);
        int r = 0;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Drive a key pattern on a falling edge; an accepted press must appear 19 edge counts later.
    task automatic applyStimulus(input logic [7:0] val, input int hold, input bit expect_valid, output int start);
        exp_t e;
        @(negedge clk);
        key_raw = val;
        start   = cycle;
        if (expect_valid) begin
            e.din = val;
            e.cyc = cycle + 19;
            e.idx = encode(val);
            sb.push_back(e);
        end
        repeat (hold) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            checkOutput("valid_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                checkOutput("valid_din", 32'(Din), 32'(mon_e.din));
                checkOutput("valid_cycle", cycle, mon_e.cyc);
                checkOutput("valid_en", 32'(en), 0);
                checkOutput("dout", encode(Din), mon_e.idx);
            end
        end
        if (rst_n) begin
            if (!en) checkOutput("inv_onehot", 32'(is_onehot(Din)), 1);
            else     checkOutput("inv_idle_zero", 32'(Din), 0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   c;
        exp_t e;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        key_raw = 8'h04;

        // Reset with a key already held.
        repeat (3) @(negedge clk);
        checkOutput("rst_din", 32'(Din), 0);
        checkOutput("rst_en", 32'(en), 1);
        checkOutput("rst_valid", 32'(key_valid), 0);
        checkOutput("rst_multi", 32'(multi_err), 0);
        rst_n = 1'b1;
        e.din = 8'h04; e.cyc = cycle + 19; e.idx = 2;
        sb.push_back(e);
        repeat (25) @(negedge clk);
        checkOutput("held_din", 32'(Din), 32'h04);

        // Asynchronous reset in the middle of a held press.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_din", 32'(Din), 0);
        checkOutput("async_en", 32'(en), 1);
        checkOutput("async_valid", 32'(key_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        e.din = 8'h04; e.cyc = cycle + 19; e.idx = 2;
        sb.push_back(e);
        repeat (25) @(negedge clk);
        applyStimulus(8'h00, 30, 0, c);

        // Clean single press and release timing.
        applyStimulus(8'h01, 40, 1, c);
        applyStimulus(8'h00, 0, 0, c);
        @(negedge clk);
        checkOutput("rel_still_held", 32'(Din), 32'h01);
        repeat (2) @(negedge clk);
        checkOutput("rel_din", 32'(Din), 0);
        checkOutput("rel_en", 32'(en), 1);
        repeat (30) @(negedge clk);

        // Bounce shorter than the debounce window.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'h10, 5, 0, c);
            applyStimulus(8'h00, 5, 0, c);
        end
        applyStimulus(8'h10, 40, 1, c);
        applyStimulus(8'h00, 30, 0, c);

        // Two keys pressed together.
        applyStimulus(8'h41, 0, 0, c);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            checkOutput("multi_din", 32'(Din), 0);
            checkOutput("multi_en", 32'(en), 1);
            if (cycle == c + 18) checkOutput("multi_err_early", 32'(multi_err), 0);
            if (cycle == c + 19) checkOutput("multi_err_set", 32'(multi_err), 1);
        end
        applyStimulus(8'h00, 0, 0, c);
        repeat (2) @(negedge clk);
        checkOutput("multi_err_hold", 32'(multi_err), 1);
        @(negedge clk);
        checkOutput("multi_err_clear", 32'(multi_err), 0);
        repeat (30) @(negedge clk);

        // Extra key added while a press is held.
        applyStimulus(8'h02, 30, 1, c);
        applyStimulus(8'h06, 0, 0, c);
        @(negedge clk);
        checkOutput("extra_still_held", 32'(Din), 32'h02);
        repeat (2) @(negedge clk);
        checkOutput("extra_din", 32'(Din), 0);
        checkOutput("extra_en", 32'(en), 1);
        repeat (40) @(negedge clk);
        applyStimulus(8'h00, 30, 0, c);
        applyStimulus(8'h02, 30, 1, c);
        applyStimulus(8'h00, 30, 0, c);

        // Sweep every key line.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'(1 << i), 30, 1, c);
            applyStimulus(8'h00, 30, 0, c);
        end

        repeat (5) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
